// File: rtl/control_registro_datos_if.sv
// Bus between the serializer control block and its external 8-bit shift
// register. The master side requests transfers and supplies the register's
// MSB output; the slave side (the controller) drives mode, load data and status.
interface control_registro_datos_if;
   logic       inicio;
   logic [7:0] dato;
   logic       q0;
   logic       s0;
   logic       s1;
   logic [7:0] p;
   logic       ser_out;
   logic       bit_valid;
   logic       busy;
   logic       done;

   modport master (
      output inicio, dato, q0,
      input  s0, s1, p, ser_out, bit_valid, busy, done
   );

   modport slave (
      input  inicio, dato, q0,
      output s0, s1, p, ser_out, bit_valid, busy, done
   );
endinterface

// File: rtl/control_registro_datos.sv
// Controller that loads a byte into an external universal shift register and
// clocks it out MSB first, holding each bit for DIV clock cycles. Mode select
// and status are Moore outputs decoded from the state and the two counters;
// ser_out passes the register's Q0 through only while shifting.
module control_registro_datos #(
   parameter int DIV = 4
) (
   input  logic clock,
   input  logic reset_n,
   control_registro_datos_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_div;
   logic [2:0] r_bit;
   logic [7:0] r_p;

   logic       w_last_cyc;
   logic       w_s0;
   logic       w_s1;
   logic       w_busy;
   logic       w_done;
   logic       w_bit_valid;
   logic       w_ser_out;

   // Last cycle of the current bit period.
   assign w_last_cyc = (r_div == 8'(DIV - 1));

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      w_next      = r_state;
      w_s0        = 1'b0;
      w_s1        = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_bit_valid = 1'b0;
      w_ser_out   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.inicio) w_next = LOAD;
         end
         LOAD: begin
            w_s1   = 1'b1;
            w_s0   = 1'b1;
            w_busy = 1'b1;
            w_next = SHIFT;
         end
         SHIFT: begin
            w_busy      = 1'b1;
            w_bit_valid = (r_div == 8'd0);
            w_ser_out   = bus.q0;
            if (w_last_cyc) begin
               // The final bit leaves the register untouched; only bits 0..6 advance it.
               if (r_bit == 3'd7) w_next = DONE;
               else               w_s1   = 1'b1;
            end
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Divider and bit counter; both restart on every load.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= 8'd0;
         r_bit <= 3'd0;
      end else if (r_state == SHIFT) begin
         if (w_last_cyc) begin
            r_div <= 8'd0;
            if (r_bit != 3'd7) r_bit <= r_bit + 3'd1;
         end else begin
            r_div <= r_div + 8'd1;
         end
      end else begin
         r_div <= 8'd0;
         r_bit <= 3'd0;
      end
   end

   // Parallel-load data, captured only when a request is accepted in IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                         r_p <= 8'h00;
      else if (r_state == IDLE && bus.inicio) r_p <= bus.dato;
   end

   assign bus.s0        = w_s0;
   assign bus.s1        = w_s1;
   assign bus.p         = r_p;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.bit_valid = w_bit_valid;
   assign bus.ser_out   = w_ser_out;

endmodule
